// File: rtl/alu_seq_pkg.sv
// Shared types for the alu_seq sequencer: opcodes, FSM state encoding, flag bundle.
// Optional feature macro ALU_SEQ_CARRY_CHAIN_EN is consumed in alu_seq.sv.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_COMP = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic c;
    logic ac;
    logic z;
    logic s;
  } flags_t;

endpackage

// File: rtl/alu_seq_alu_core.sv
// Combinational 8-bit ALU: result plus carry/borrow, half-carry/borrow, zero and sign.
module alu_core
  import alu_seq_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [2:0] i_op,
  input  logic       i_cin,
  output logic [7:0] o_res,
  output logic       o_c,
  output logic       o_ac,
  output logic       o_z,
  output logic       o_s
);

  logic [8:0] w_wide;
  logic [4:0] w_nib;

  always_comb begin
    w_wide = '0;
    w_nib  = '0;
    o_res  = '0;
    o_c    = 1'b0;
    o_ac   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_wide = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
        w_nib  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'd0, i_cin};
        o_res  = w_wide[7:0];
        o_c    = w_wide[8];
        o_ac   = w_nib[4];
      end
      // Bit 8/bit 4 of the widened difference is the borrow out.
      OP_SUB: begin
        w_wide = {1'b0, i_a} - {1'b0, i_b} - {8'd0, i_cin};
        w_nib  = {1'b0, i_a[3:0]} - {1'b0, i_b[3:0]} - {4'd0, i_cin};
        o_res  = w_wide[7:0];
        o_c    = w_wide[8];
        o_ac   = w_nib[4];
      end
      OP_COMP: o_res = ~i_a;
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_NAND: o_res = ~(i_a & i_b);
      OP_NOR:  o_res = ~(i_a | i_b);
      default: o_res = i_a ^ i_b;
    endcase
  end

  assign o_z = (o_res == 8'h00);
  assign o_s = o_res[7];

endmodule

// File: rtl/alu_seq.sv
// Command sequencer around alu_core: 4-entry register file (r0 hardwired to 0), flags, response handshake.
// Define ALU_SEQ_CARRY_CHAIN_EN to let cmd_cin feed the stored carry into ADD/SUB.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_rd,
  input  logic [1:0]  cmd_rs1,
  input  logic [1:0]  cmd_rs2,
  input  logic        cmd_imm_en,
  input  logic [7:0]  cmd_imm,
  input  logic        cmd_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_res,
  output logic        flag_c,
  output logic        flag_ac,
  output logic        flag_z,
  output logic        flag_s,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [15:0] op_count
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_op;
  logic [1:0]  r_rd;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_cin_req;
  logic [7:0]  r_regs [1:3];
  logic [7:0]  r_res;
  flags_t      r_flags;
  logic [15:0] r_count;

  logic [7:0]  w_rs1_val;
  logic [7:0]  w_rs2_val;
  logic        w_cin_req;
  logic        w_cin;
  logic [7:0]  w_res;
  flags_t      w_flags;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign w_cin_req = cmd_cin && ((cmd_op == OP_ADD) || (cmd_op == OP_SUB));
`else
  logic w_unused_cin;
  assign w_unused_cin = cmd_cin;
  assign w_cin_req    = 1'b0;
`endif

  // Flags only change in EXEC, so flag_c here is the previous operation's carry.
  assign w_cin = r_cin_req & r_flags.c;

  always_comb begin
    w_rs1_val = 8'h00;
    w_rs2_val = 8'h00;
    dbg_data  = 8'h00;
    case (cmd_rs1)
      2'd1:    w_rs1_val = r_regs[1];
      2'd2:    w_rs1_val = r_regs[2];
      2'd3:    w_rs1_val = r_regs[3];
      default: w_rs1_val = 8'h00;
    endcase
    case (cmd_rs2)
      2'd1:    w_rs2_val = r_regs[1];
      2'd2:    w_rs2_val = r_regs[2];
      2'd3:    w_rs2_val = r_regs[3];
      default: w_rs2_val = 8'h00;
    endcase
    case (dbg_addr)
      2'd1:    dbg_data = r_regs[1];
      2'd2:    dbg_data = r_regs[2];
      2'd3:    dbg_data = r_regs[3];
      default: dbg_data = 8'h00;
    endcase
  end

  alu_core u_alu_core (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .i_cin (w_cin),
    .o_res (w_res),
    .o_c   (w_flags.c),
    .o_ac  (w_flags.ac),
    .o_z   (w_flags.z),
    .o_s   (w_flags.s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_ADD;
      r_rd      <= 2'd0;
      r_a       <= 8'h00;
      r_b       <= 8'h00;
      r_cin_req <= 1'b0;
      r_regs[1] <= 8'h00;
      r_regs[2] <= 8'h00;
      r_regs[3] <= 8'h00;
      r_res     <= 8'h00;
      r_flags   <= '0;
      r_count   <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op      <= cmd_op;
            r_rd      <= cmd_rd;
            r_a       <= w_rs1_val;
            r_b       <= cmd_imm_en ? cmd_imm : w_rs2_val;
            r_cin_req <= w_cin_req;
          end
        end
        ST_EXEC: begin
          r_res   <= w_res;
          r_flags <= w_flags;
          case (r_rd)
            2'd1:    r_regs[1] <= w_res;
            2'd2:    r_regs[2] <= w_res;
            2'd3:    r_regs[3] <= w_res;
            default: ;
          endcase
        end
        ST_RESP: begin
          if (rsp_ready) r_count <= r_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_res  = r_res;
  assign flag_c   = r_flags.c;
  assign flag_ac  = r_flags.ac;
  assign flag_z   = r_flags.z;
  assign flag_s   = r_flags.s;
  assign op_count = r_count;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected {res,flags}, monitor pops on each response handshake.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_rd;
  logic [1:0]  cmd_rs1;
  logic [1:0]  cmd_rs2;
  logic        cmd_imm_en;
  logic [7:0]  cmd_imm;
  logic        cmd_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_res;
  logic        flag_c, flag_ac, flag_z, flag_s;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [11:0] exp_q [$];

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm_en (cmd_imm_en),
    .cmd_imm    (cmd_imm),
    .cmd_cin    (cmd_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .flag_c     (flag_c),
    .flag_ac    (flag_ac),
    .flag_z     (flag_z),
    .flag_s     (flag_s),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reg(input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    check($sformatf("dbg_r%0d", addr), {8'h00, dbg_data}, {8'h00, exp});
  endtask

  // Call aligned #1 after a rising edge; returns aligned the same way with the DUT back in IDLE.
  task automatic do_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                       input logic cin, input logic [7:0] e_res, input logic [3:0] e_fl,
                       input int stall);
    int k;
    exp_q.push_back({e_res, e_fl});
    rsp_ready = (stall == 0);
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 16'd0, 16'd1);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_cin = cin;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rsp_latency", {15'd0, rsp_valid}, 16'd1);
    check("busy_ready", {15'd0, cmd_ready}, 16'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", {15'd0, rsp_valid}, 16'd1);
      check("stall_res", {8'h00, rsp_res}, {8'h00, e_res});
      check("stall_flags", {12'd0, flag_c, flag_ac, flag_z, flag_s}, {12'd0, e_fl});
      check("stall_ready", {15'd0, cmd_ready}, 16'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("resume_ready", {15'd0, cmd_ready}, 16'd1);
    n_done++;
    check("op_count", op_count, n_done[15:0]);
  endtask

  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %h expected none", rsp_res);
        end else begin
          e = exp_q.pop_front();
          check("rsp_res", {8'h00, rsp_res}, {8'h00, e[11:4]});
          check("rsp_flags", {12'd0, flag_c, flag_ac, flag_z, flag_s}, {12'd0, e[3:0]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_ADD; cmd_rd = 2'd0; cmd_rs1 = 2'd0;
    cmd_rs2 = 2'd0; cmd_imm_en = 1'b0; cmd_imm = 8'h00; cmd_cin = 1'b0;
    rsp_ready = 1'b1; dbg_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    check("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst_rsp_res", {8'h00, rsp_res}, 16'h0000);
    check("rst_flags", {12'd0, flag_c, flag_ac, flag_z, flag_s}, 16'h0000);
    check("rst_op_count", op_count, 16'h0000);
    for (int r = 0; r < 4; r++) check_reg(r[1:0], 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // op, rd, rs1, rs2, imm_en, imm, cin, exp_res, exp {C,AC,Z,S}, stall
    do_op(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h3C, 1'b0, 8'h3C, 4'b0000, 0);
    do_op(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'hC4, 1'b0, 8'hC4, 4'b0001, 0);
    do_op(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h00, 4'b1110, 0);
    check_reg(2'd3, 8'h00);
    check_reg(2'd1, 8'h3C);
    do_op(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10, 1'b0, 8'h10, 4'b0000, 0);
    do_op(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 8'h01, 4'b0000, 0);
    do_op(OP_SUB, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, 1'b0, 8'h0F, 4'b0100, 0);
    check_reg(2'd3, 8'h0F);
    do_op(OP_SUB, 2'd3, 2'd2, 2'd0, 1'b1, 8'h02, 1'b0, 8'hFF, 4'b1101, 0);
    do_op(OP_XOR, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0010, 0);
    check_reg(2'd1, 8'h00);
    do_op(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h0F, 1'b0, 8'h0F, 4'b0000, 0);
    do_op(OP_COMP, 2'd2, 2'd3, 2'd0, 1'b0, 8'h00, 1'b0, 8'hF0, 4'b0001, 0);
    check_reg(2'd2, 8'hF0);
    do_op(OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h55, 1'b0, 8'h55, 4'b0000, 0);
    check_reg(2'd0, 8'h00);
    do_op(OP_AND, 2'd1, 2'd2, 2'd0, 1'b1, 8'h3C, 1'b0, 8'h30, 4'b0000, 5);
    do_op(OP_OR,  2'd1, 2'd2, 2'd0, 1'b1, 8'h0F, 1'b0, 8'hFF, 4'b0001, 0);
    do_op(OP_NAND, 2'd1, 2'd2, 2'd0, 1'b1, 8'hF0, 1'b0, 8'h0F, 4'b0000, 0);
    do_op(OP_NOR, 2'd1, 2'd2, 2'd0, 1'b1, 8'h0F, 1'b0, 8'h00, 4'b0010, 0);
    check_reg(2'd1, 8'h00);

    // Set C=1, then ADD 0x01+0x01 with cmd_cin.
    do_op(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 8'h01, 4'b0000, 0);
    do_op(OP_SUB, 2'd1, 2'd0, 2'd0, 1'b1, 8'h01, 1'b0, 8'hFF, 4'b1101, 0);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    do_op(OP_ADD, 2'd2, 2'd3, 2'd0, 1'b1, 8'h01, 1'b1, 8'h03, 4'b0000, 0);
    check_reg(2'd2, 8'h03);
`else
    do_op(OP_ADD, 2'd2, 2'd3, 2'd0, 1'b1, 8'h01, 1'b1, 8'h02, 4'b0000, 0);
    check_reg(2'd2, 8'h02);
`endif

    // Reset asserted while the command is in EXEC.
    cmd_op = OP_ADD; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'h77;
    cmd_cin = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check("abort_op_count", op_count, 16'h0000);
    check("abort_cmd_ready", {15'd0, cmd_ready}, 16'd1);
    check_reg(2'd3, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("abort_no_rsp", {15'd0, rsp_valid}, 16'd0);
    end
    check_reg(2'd3, 8'h00);
    check("abort_count_after", op_count, 16'h0000);
    check("queue_drained", exp_q.size(), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command-driven sequencer that wraps the 8-bit ALU datapath with a 4-entry register file and a persistent flag register. It accepts one operation per valid/ready command, reads operands, executes on the ALU, writes back the result and updates the flags, then returns the result on a response handshake. It sits between the control/test logic and the ALU, and is the only user of the ALU in the ALU/memory/comparator subsystem.

## Interface
- No parameters; data width fixed at 8, register count fixed at 4.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept command
- cmd_op  in  3  ADD 000, SUB 001, COMP 010, AND 011, OR 100, NAND 101, NOR 110, XOR 111
- cmd_rd  in  2  destination register
- cmd_rs1  in  2  operand-1 register
- cmd_rs2  in  2  operand-2 register (ignored when cmd_imm_en)
- cmd_imm_en  in  1  operand 2 comes from cmd_imm
- cmd_imm  in  8  immediate operand
- cmd_cin  in  1  use stored C as carry/borrow-in (see Configuration)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_res  out  8  result
- flag_c, flag_ac, flag_z, flag_s  out  1 each  flag register
- dbg_addr  in  2  debug register-read address
- dbg_data  out  8  combinational read of register dbg_addr
- op_count  out  16  completed-operation counter

## Operation
- Registers r0..r3; r0 reads as 0x00 always, writes to r0 discarded (result still reported). Load = ADD rd, r0, imm.
- FSM states IDLE, EXEC, RESP. IDLE: cmd_ready=1; on cmd_valid, latch op, rd and operands (rs1 value; rs2 value or imm) -> EXEC. EXEC: ALU evaluates latched operands; result to rsp_res register, flags updated, rd written -> RESP. RESP: rsp_valid=1; on rsp_ready -> IDLE, op_count increments (wraps 0xFFFF -> 0x0000).
- ADD: {C,res} = a + b (+cin); AC = carry out of bit 3.
- SUB: res = a - b (- cin); C = 1 iff borrow (a < b + cin); AC = borrow out of low nibble.
- COMP: res = ~a; b ignored.
- Logic ops and COMP: C and AC cleared.
- All ops: Z = (res == 0), S = res[7].
- Flags persist until the next EXEC.

## Timing
- Reset: state IDLE, all registers 0x00, flags 0, rsp_valid 0, rsp_res 0x00, op_count 0; cmd_ready 1 immediately.
- Accept edge T; EXEC during T+1; rsp_valid, flags, register write visible after edge T+1; earliest next accept edge T+3 (rsp_ready held high). Throughput one op per 3 cycles.
- rsp_res and flags stable while rsp_valid && !rsp_ready; cmd_ready 0 throughout EXEC and RESP.
- Write-back completes before next accept: no read-after-write hazard.
- Reset mid-EXEC/RESP: operation aborted, no write-back, no response, no count.

## Configuration
- ALU_SEQ_CARRY_CHAIN_EN defined: cmd_cin=1 on ADD/SUB injects stored flag_c as carry-in/borrow-in (multi-byte arithmetic); ignored on other ops.
- Undefined: cmd_cin ignored, carry-in always 0; port remains.

## Structure
- Package alu_seq_pkg: 3-bit opcode constants, FSM state encoding, flag bundle typedef.
- One sub-module alu_core: combinational ALU (a, b, op, cin -> res, c, ac, z, s) per the arithmetic rules above; sequencer holds all state.

## Test plan
- Load r1=0x3C, r2=0xC4 via ADD rd,r0,imm; ADD r3=r1+r2 -> rsp_res 0x00, C=1, AC=1, Z=1, S=0; dbg r3 = 0x00.
- SUB 0x10-0x01 -> 0x0F, C=0, AC=1, Z=0, S=0; SUB 0x01-0x02 -> 0xFF, C=1, AC=1, S=1.
- After C=1, XOR r1,r1 -> 0x00, Z=1, C=0, AC=0; COMP on 0x0F -> 0xF0, S=1.
- ADD rd=r0, imm 0x55 -> rsp_res 0x55, dbg r0 still 0x00; op_count increments per response.
- rsp_ready low 5 cycles in RESP -> rsp_res/flags stable, cmd_ready 0; accept resumes T+1 after handshake.
- rst_n low during EXEC -> no write, rsp_valid 0, op_count unchanged; macro on: C=1, ADD cin 0x01+0x01 -> 0x03.
